biriscv_fetch_queue: RTL
========================

Name: biriscv_fetch_queue

Overview:
- Dual-slot instruction queue between the frontend's fetch0/fetch1 outputs and the issue stage.
- Absorbs decode/issue rate mismatch: up to two pre-decoded instructions enqueued and up to two dequeued per cycle, strictly in program order.
- Flushed on pipeline redirect.
- Presents the same valid/accept handshake on both sides, so the frontend connects unchanged.

Parameters:
DEPTH, 8, number of entries; power of two, >= 4
DEPTH_W, 3, log2(DEPTH)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  discard all contents (branch redirect / exception)
in0_valid_i  in  1  frontend slot 0 valid (older)
in0_instr_i  in  32  slot 0 instruction
in0_pc_i  in  32  slot 0 PC
in0_flags_i  in  10  {invalid,rd_valid,csr,div,mul,branch,lsu,exec,fault_page,fault_fetch}
in0_accept_o  out  1  slot 0 accepted
in1_valid_i  in  1  frontend slot 1 valid (younger)
in1_instr_i  in  32  slot 1 instruction
in1_pc_i  in  32  slot 1 PC
in1_flags_i  in  10  as in0_flags_i
in1_accept_o  out  1  slot 1 accepted
out0_valid_o  out  1  head entry valid
out0_instr_o  out  32  head instruction
out0_pc_o  out  32  head PC
out0_flags_o  out  10  head flags
out0_accept_i  in  1  issue consumes head
out1_valid_o  out  1  head+1 entry valid
out1_instr_o  out  32  head+1 instruction
out1_pc_o  out  32  head+1 PC
out1_flags_o  out  10  head+1 flags
out1_accept_i  in  1  issue consumes head+1
level_o  out  DEPTH_W+1  current occupancy

Behaviour:
- State:
  - Entry array of DEPTH x 74 bits.
  - rd_ptr and wr_ptr, DEPTH_W bits each, wrap modulo DEPTH.
  - count, DEPTH_W+1 bits, range 0..DEPTH.
- Reset (rst_ni low, asynchronous):
  - rd_ptr = wr_ptr = count = 0.
  - All out*_valid_o = 0, level_o = 0.
  - in0_accept_o = in1_accept_o = 1.
  - Entry contents are don't-care.
- Accept (combinational from registered count only, no same-cycle pop bypass):
  - in0_accept_o = (DEPTH - count) >= 1.
  - in1_accept_o = (DEPTH - count) >= 2.
- Enqueue, rule A:
  - Slot 1 is written only when slot 0 is valid and accepted, or when slot 0 is not valid.
  - If in0_valid_i and !in0_accept_o, slot 1 is not written, regardless of in1_accept_o.
- Enqueue, rule B:
  - Valid, accepted slots are written at wr_ptr and wr_ptr+1 in slot order (slot 0 first).
  - A lone in1 is written at wr_ptr.
  - push = 0..2.
- Dequeue (outputs are direct reads of the array, zero-latency):
  - out0 = entry[rd_ptr], out0_valid_o = count >= 1.
  - out1 = entry[rd_ptr+1 mod DEPTH], out1_valid_o = count >= 2.
  - pop0 = out0_valid_o & out0_accept_i.
  - pop1 = out1_valid_o & out1_accept_i & pop0; out1 is never popped without out0.
  - pop = pop0 + pop1.
- Update per cycle:
  - count += push - pop.
  - wr_ptr += push, rd_ptr += pop (modulo DEPTH).
  - Simultaneous push and pop at any level, including full and empty, is legal.
  - Full: pushes are blocked by accept only; same-cycle pops do not enable pushes.
- Latency:
  - An entry enqueued in cycle N is visible on out0/out1 in cycle N+1.
  - There is no input-to-output flow-through.
- Flush (flush_i high):
  - Next cycle rd_ptr = wr_ptr = count = 0.
  - Same-cycle pushes and pops are discarded.
  - Outputs in the flush cycle still reflect pre-flush state; issue must ignore them in that cycle (issue already qualifies on flush).
  - Reset takes precedence over flush.
- Flags and data pass through unmodified; the block performs no decode.
- level_o = count.

Test Plan:
- Reset, then DEPTH=8, push pairs (PC 0x80000000/0x80000004 ...) with outputs blocked:
  - after 4 cycles count=8, in0_accept_o=0, in1_accept_o=0, out0_pc_o=0x80000000, out1_pc_o=0x80000004.
- count=7, both in valid:
  - in0_accept_o=1, in1_accept_o=0; only slot 0 written; count=8 next cycle.
- Wrap-around: cycle 20 entries through with continuous push 2 / pop 2:
  - PCs emerge in order, count stays constant, ptrs wrap 7->0 without loss.
- out0_accept_i=0, out1_accept_i=1 with count=3:
  - nothing popped; count stays 3.
- Then out0_accept_i=1, out1_accept_i=1:
  - count=1; out0 shows third entry.
- Flush with count=5 plus a simultaneous push of 2 and pop of 1:
  - next cycle count=0, out0_valid_o=0, level_o=0; pushed PCs never appear.
- Assert rst_ni low asynchronously mid-stream (between clock edges) with count=6:
  - outputs go invalid immediately, level_o=0; after release the first push appears next cycle on out0.

Source files
------------

// File: rtl/biriscv_fetch_queue.sv
// biriscv_fetch_queue: dual-slot in-order instruction queue between fetch and issue.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   flush_i                drop all contents (redirect / exception)
//   in{0,1}_*              frontend slots (0 older), valid/accept handshake
//   out{0,1}_*             head and head+1 entries, valid/accept handshake
//   level_o                current occupancy
module biriscv_fetch_queue #(
    parameter int DEPTH   = 8,
    parameter int DEPTH_W = 3
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               in0_valid_i,
    input  logic [31:0]        in0_instr_i,
    input  logic [31:0]        in0_pc_i,
    input  logic [9:0]         in0_flags_i,
    output logic               in0_accept_o,
    input  logic               in1_valid_i,
    input  logic [31:0]        in1_instr_i,
    input  logic [31:0]        in1_pc_i,
    input  logic [9:0]         in1_flags_i,
    output logic               in1_accept_o,
    output logic               out0_valid_o,
    output logic [31:0]        out0_instr_o,
    output logic [31:0]        out0_pc_o,
    output logic [9:0]         out0_flags_o,
    input  logic               out0_accept_i,
    output logic               out1_valid_o,
    output logic [31:0]        out1_instr_o,
    output logic [31:0]        out1_pc_o,
    output logic [9:0]         out1_flags_o,
    input  logic               out1_accept_i,
    output logic [DEPTH_W:0]   level_o
);
    localparam logic [DEPTH_W:0] FULL = (DEPTH_W+1)'(DEPTH);
    logic [73:0]        mem_q [DEPTH];
    logic [DEPTH_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [DEPTH_W:0]   count_q, count_d;
    logic               wr0, wr1, pop0, pop1;
    logic [1:0]         push, pop;
    logic [73:0]        head0, head1;

    assign in0_accept_o = count_q < FULL;
    assign in1_accept_o = count_q <= FULL - (DEPTH_W+1)'(2);
    // slot 1 may only enter behind slot 0, never ahead of a stalled older slot
    assign wr0  = in0_valid_i & in0_accept_o;
    assign wr1  = in1_valid_i & in1_accept_o & (~in0_valid_i | in0_accept_o);
    assign push = {1'b0, wr0} + {1'b0, wr1};
    assign head0 = mem_q[rd_ptr_q];
    assign head1 = mem_q[rd_ptr_q + DEPTH_W'(1)];
    assign out0_valid_o = count_q != '0;
    assign out1_valid_o = count_q > (DEPTH_W+1)'(1);
    assign {out0_flags_o, out0_pc_o, out0_instr_o} = head0;
    assign {out1_flags_o, out1_pc_o, out1_instr_o} = head1;
    assign pop0 = out0_valid_o & out0_accept_i;
    assign pop1 = out1_valid_o & out1_accept_i & pop0;
    assign pop  = {1'b0, pop0} + {1'b0, pop1};
    assign level_o = count_q;

    always_comb begin
        rd_ptr_d = flush_i ? '0 : rd_ptr_q + DEPTH_W'(pop);
        wr_ptr_d = flush_i ? '0 : wr_ptr_q + DEPTH_W'(push);
        count_d  = flush_i ? '0 : count_q + (DEPTH_W+1)'(push) - (DEPTH_W+1)'(pop);
    end

    // a lone slot 1 lands at wr_ptr; behind slot 0 it lands at wr_ptr+1
    always_ff @(posedge clk_i) begin
        if (wr0) mem_q[wr_ptr_q] <= {in0_flags_i, in0_pc_i, in0_instr_i};
        if (wr1) mem_q[wr_ptr_q + DEPTH_W'(wr0)] <= {in1_flags_i, in1_pc_i, in1_instr_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule
